// File: rtl/seg_mux_scheduler.sv
// Seven-segment scan scheduler: emits {one-hot select, segments} words to the
// shift-register serializer, dwelling per digit; shadow applied per frame.
module seg_mux_scheduler #(
  parameter int NUM_DIGITS   = 3,
  parameter int SEL_WIDTH    = 8,
  parameter int DWELL_CYCLES = 2048,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  input  logic                      i_wr_en,
  input  logic [4*NUM_DIGITS-1:0]   i_wr_digits,
  input  logic [NUM_DIGITS-1:0]     i_blank_mask,
  output logic [SEL_WIDTH+7:0]      o_word,
  output logic                      o_word_valid,
  input  logic                      i_word_ready,
  output logic [IW-1:0]             o_digit_idx,
  output logic                      o_frame_done,
  output logic                      o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DWELL,
    BLANK
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] DMAX = CW'(DWELL_CYCLES - 1);

  state_t                  state_q;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q;
  logic [IW-1:0]           idx_q;
  logic [CW-1:0]           cnt_q;
  logic [SEL_WIDTH+7:0]    word_q;
  logic                    valid_q;
  logic                    frame_q;
  logic                    busy_q;

  function automatic logic [7:0] hex7(input logic [3:0] h);
    logic [7:0] s;
    unique case (h)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      4'hF: s = 8'h71;
    endcase
    return s;
  endfunction

  function automatic logic [SEL_WIDTH+7:0] build(
    input logic [IW-1:0]           k,
    input logic [4*NUM_DIGITS-1:0] d,
    input logic [NUM_DIGITS-1:0]   m
  );
    logic [SEL_WIDTH-1:0]    sel;
    logic [4*NUM_DIGITS-1:0] ds;
    logic [NUM_DIGITS-1:0]   ms;
    sel = SEL_WIDTH'(1) << k;
    ds  = d >> {k, 2'b00};
    ms  = m >> k;
    return {sel, ms[0] ? 8'h00 : hex7(ds[3:0])};
  endfunction

  // A write on the copy edge must win, so copies take the next shadow value.
  assign shadow_d = i_wr_en ? i_wr_digits : shadow_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      active_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      frame_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      frame_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_enable) begin
            state_q  <= SEND;
            active_q <= shadow_d;
            idx_q    <= '0;
            word_q   <= build('0, shadow_d, i_blank_mask);
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        SEND: begin
          if (i_word_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            if (i_enable) begin
              state_q <= DWELL;
            end else begin
              state_q <= BLANK;
              word_q  <= '0;
            end
          end
        end
        DWELL: begin
          if (cnt_q == DMAX) begin
            valid_q <= 1'b1;
            if (!i_enable) begin
              state_q <= BLANK;
              word_q  <= '0;
            end else begin
              state_q <= SEND;
              if (idx_q == LAST) begin
                idx_q    <= '0;
                active_q <= shadow_d;
                frame_q  <= 1'b1;
                word_q   <= build('0, shadow_d, i_blank_mask);
              end else begin
                idx_q  <= idx_q + 1'b1;
                word_q <= build(idx_q + 1'b1, active_q, i_blank_mask);
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BLANK: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (i_word_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = valid_q;
  assign o_digit_idx  = idx_q;
  assign o_frame_done = frame_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// Bench for seg_mux_scheduler: event-level scan model plus directed
// scenarios and randomized ready/write/mask traffic.
module tb_seg_mux_scheduler;

  localparam int N = 3;
  localparam int D = 4;

  localparam logic [7:0] SEG [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        wr_en;
  logic [11:0] wr_d;
  logic [2:0]  mask;
  logic [15:0] word;
  logic        valid;
  logic        ready;
  logic [1:0]  idx;
  logic        fdone;
  logic        busy;

  always #5 clk = ~clk;

  seg_mux_scheduler #(
    .NUM_DIGITS  (N),
    .SEL_WIDTH   (8),
    .DWELL_CYCLES(D)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_enable    (en),
    .i_wr_en     (wr_en),
    .i_wr_digits (wr_d),
    .i_blank_mask(mask),
    .o_word      (word),
    .o_word_valid(valid),
    .i_word_ready(ready),
    .o_digit_idx (idx),
    .o_frame_done(fdone),
    .o_busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  logic [11:0] sh;
  logic [11:0] frame;
  int          m_run;
  int          k_exp;
  int          cyc;
  int          acc_edge;
  logic [15:0] acc_words[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(
    int k, logic [11:0] d, logic [2:0] m
  );
    logic [7:0] s;
    logic [7:0] sel;
    s   = m[k] ? 8'h00 : SEG[d[4*k +: 4]];
    sel = 8'(1 << k);
    return {sel, s};
  endfunction

  task automatic present(bit wrap);
    chk("word", {16'h0, word}, {16'h0, exp_word(k_exp, frame, mask)});
    chk("idx", {30'h0, idx}, k_exp);
    chk("frame_done", {31'h0, fdone}, {31'h0, wrap});
  endtask

  task automatic tick();
    logic        acc;
    logic        pv;
    logic [15:0] pw;
    acc = valid && ready;
    pv  = valid;
    pw  = word;
    @(posedge clk);
    cyc++;
    if (wr_en) sh = wr_d;
    #1;
    if (acc) begin
      acc_words.push_back(pw);
      acc_edge = cyc;
      chk("valid_drop", {31'h0, valid}, 0);
      if (m_run == 2) begin
        m_run = 0;
        chk("busy_after_blank", {31'h0, busy}, 0);
      end
    end else if (pv) begin
      chk("hold_valid", {31'h0, valid}, 1);
      chk("hold_word", {16'h0, word}, {16'h0, pw});
    end else if (m_run == 0) begin
      chk("idle_start", {31'h0, valid}, {31'h0, en});
      chk("idle_busy", {31'h0, busy}, {31'h0, en});
      if (en) begin
        m_run = 1;
        k_exp = 0;
        frame = sh;
        present(1'b0);
      end
    end else if (cyc - acc_edge == D) begin
      chk("dwell_rise", {31'h0, valid}, 1);
      if (!en) begin
        m_run = 2;
        chk("blank_word", {16'h0, word}, 0);
        chk("blank_busy", {31'h0, busy}, 1);
      end else begin
        k_exp = (k_exp + 1) % N;
        if (k_exp == 0) frame = sh;
        present(k_exp == 0);
      end
    end else begin
      chk("dwell_quiet", {31'h0, valid}, 0);
      chk("dwell_fdone", {31'h0, fdone}, 0);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_word"}, {16'h0, word}, 0);
    chk({tag, "_valid"}, {31'h0, valid}, 0);
    chk({tag, "_idx"}, {30'h0, idx}, 0);
    chk({tag, "_fdone"}, {31'h0, fdone}, 0);
    chk({tag, "_busy"}, {31'h0, busy}, 0);
  endtask

  task automatic wait_digit(int k);
    for (int n = 0; n < 60 && !(valid && idx == 2'(k)); n++) tick();
    chk("sync_digit", {31'h0, valid}, 1);
  endtask

  initial begin
    logic [11:0] nv;
    int          n0;
    rst_n = 1'b0;
    en    = 1'b0;
    wr_en = 1'b0;
    wr_d  = '0;
    mask  = '0;
    ready = 1'b1;
    sh    = '0;
    frame = '0;
    m_run = 0;
    k_exp = 0;
    cyc   = 0;
    acc_edge = 0;
    #1;
    check_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // write and enable on the same edge: the copy must see the new value
    en    = 1'b1;
    wr_en = 1'b1;
    wr_d  = 12'h3A7;
    tick();
    wr_en = 1'b0;
    repeat (20) tick();
    chk("t1_w0", {16'h0, acc_words[0]}, 32'h0107);
    chk("t1_w1", {16'h0, acc_words[1]}, 32'h0277);
    chk("t1_w2", {16'h0, acc_words[2]}, 32'h044F);

    // ready stall on digit 1
    wait_digit(1);
    ready = 1'b0;
    repeat (10) tick();
    ready = 1'b1;
    repeat (6) tick();

    // mid-frame write, then a write landing exactly on the wrap edge
    wait_digit(1);
    wr_en = 1'b1;
    wr_d  = 12'h123;
    tick();
    wr_en = 1'b0;
    wait_digit(2);
    tick();
    repeat (D - 1) tick();
    nv    = 12'h5E9;
    wr_en = 1'b1;
    wr_d  = nv;
    tick();
    wr_en = 1'b0;
    chk("wrap_bypass", {16'h0, word}, {16'h0, exp_word(0, nv, mask)});

    // blank mask on digit 1
    mask = 3'b010;
    wait_digit(1);
    chk("mask_word", {16'h0, word}, 32'h0200);
    tick();
    mask = 3'b000;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 9) < 7);
      wr_en = ($urandom_range(0, 15) == 0);
      wr_d  = 12'($urandom);
      if ($urandom_range(0, 19) == 0) mask = 3'($urandom);
      tick();
    end
    wr_en = 1'b0;
    mask  = 3'b000;
    ready = 1'b1;

    // enable drop during dwell of digit 2
    wait_digit(2);
    tick();
    tick();
    en = 1'b0;
    for (int n = 0; n < 30 && m_run != 0; n++) tick();
    chk("drop_idle", m_run, 0);
    chk("drop_last", {16'h0, acc_words[$]}, 0);
    tick();
    chk("drop_valid", {31'h0, valid}, 0);
    chk("drop_busy", {31'h0, busy}, 0);

    // reset while a word is stalled
    en    = 1'b1;
    ready = 1'b0;
    n0    = 0;
    while (!valid && n0 < 10) begin
      tick();
      n0++;
    end
    chk("pre_reset_valid", {31'h0, valid}, 1);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    sh    = '0;
    m_run = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    tick();
    chk("restart_word", {16'h0, word}, 32'h013F);
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
